// File: rtl/bram_to_axis.sv
// Drains a contiguous block of BRAM words onto an AXI4-Stream master port.
// Reads are credit-limited so the FIFO never overflows and tready never reaches bram_en.
module bram_to_axis #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int BRAM_LATENCY = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int DEPTH = BRAM_LATENCY + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int CW1   = CW + 1;
  localparam logic [PW-1:0]       PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW:0]         DEPTH_C  = CW1'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     len_q, len_d, rd_left_q, rd_left_d, ld_cnt_q, ld_cnt_d;
  logic [BRAM_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           cnt_q;
  logic [DATA_WIDTH-1:0]   tdata_q;
  logic                    tvalid_q, tlast_q;
  logic [CW:0]             in_flight, credit_use;
  logic                    issue, push, pop, accept;

  // FIFO occupancy excludes the output register, which keeps one beat per cycle sustainable
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < BRAM_LATENCY; i++) begin
      in_flight = in_flight + {{CW{1'b0}}, vld_q[i]};
    end
  end

  assign credit_use = in_flight + {1'b0, cnt_q};
  assign issue      = (state_q == S_READ) && (credit_use < DEPTH_C);
  assign push       = vld_q[BRAM_LATENCY-1];
  assign pop        = (cnt_q != '0) && (!tvalid_q || m_axis_tready);
  assign accept     = tvalid_q && m_axis_tready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (length == '0) ? S_DONE : S_READ;
      S_READ:  if (issue && rd_left_q == LEN_ONE) state_d = S_FLUSH;
      S_FLUSH: if (accept && tlast_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == S_READ) || (state_q == S_FLUSH);
    done    = (state_q == S_DONE);
    bram_en = issue;
  end

  assign bram_addr     = addr_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;

  always_comb begin
    addr_d    = addr_q;
    len_d     = len_q;
    rd_left_d = rd_left_q;
    ld_cnt_d  = ld_cnt_q;
    vld_d     = vld_q << 1;
    vld_d[0]  = issue;
    if (state_q == S_IDLE && start) begin
      addr_d    = base_addr;
      len_d     = length;
      rd_left_d = length;
      ld_cnt_d  = '0;
    end else begin
      if (issue) begin
        addr_d    = addr_q + 1'b1;
        rd_left_d = rd_left_q - 1'b1;
      end
      if (pop) ld_cnt_d = ld_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr_q    <= '0;
      len_q     <= '0;
      rd_left_q <= '0;
      ld_cnt_q  <= '0;
      vld_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      len_q     <= len_d;
      rd_left_q <= rd_left_d;
      ld_cnt_q  <= ld_cnt_d;
      vld_q     <= vld_d;
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
      if (pop) begin
        tdata_q  <= mem_q[rd_ptr_q];
        tvalid_q <= 1'b1;
        tlast_q  <= (ld_cnt_q + 1'b1 == len_q);
      end else if (accept) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) mem_q[wr_ptr_q] <= bram_dout;
  end

endmodule
